vga_pixel_stream: RTL

VGA_PIXEL_STREAM -- requirements
Module: vga_pixel_stream

---
 rtl/vga_pixel_stream.sv | 129 ++++++++++++
 1 files changed

// File: rtl/vga_pixel_stream.sv
// vga_pixel_stream: VGA timing generator fed by a pixel FIFO, one pop per visible position.
// Ports: clk, rst_n (async active-low); enable runs the timing generator;
// data_in/data_valid/data_ready push {R,G,B} pixels; red/green/blue, hsync, vsync,
// active, frame_start and underrun are registered one clock after the counter position.
// Optional: define VGA_UNDERRUN_CNT_EN to add the saturating 16-bit underrun_cnt output.
module vga_pixel_stream #(
    parameter int CH_BITS    = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [3*CH_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic [CH_BITS-1:0]   red,
    output logic [CH_BITS-1:0]   green,
    output logic [CH_BITS-1:0]   blue,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 active,
    output logic                 frame_start,
    output logic                 underrun
`ifdef VGA_UNDERRUN_CNT_EN
    ,
    output logic [15:0]          underrun_cnt
`endif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = 3 * CH_BITS;
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] mem [FIFO_DEPTH];
    logic          ready_q;
    logic          full;
    logic          empty;
    logic          push;
    logic          vis;
    logic          pop;
    logic          h_on;
    logic          v_on;

    // The extra pointer bit separates full (MSBs differ) from empty (equal).
    always_comb begin
        full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        empty      = wr_ptr == rd_ptr;
        data_ready = ready_q && !full;
        push       = data_valid && data_ready;
        vis        = enable && (h_cnt < H_ACT) && (v_cnt < V_ACT);
        pop        = vis && !empty;
        h_on       = enable && (h_cnt >= H_SS) && (h_cnt < H_SE);
        v_on       = enable && (v_cnt >= V_SS) && (v_cnt < V_SE);
    end

    // ready_q keeps data_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (!enable) begin
                h_cnt <= '0;
                v_cnt <= '0;
            end else begin
                h_cnt <= (h_cnt == H_LAST) ? '0 : h_cnt + 1'b1;
                if (h_cnt == H_LAST) v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {red, green, blue} <= '0;
            active             <= 1'b0;
            frame_start        <= 1'b0;
            underrun           <= 1'b0;
            hsync              <= !SYNC_POL;
            vsync              <= !SYNC_POL;
        end else begin
            {red, green, blue} <= pop ? mem[rd_ptr[AW-1:0]] : '0;
            active             <= vis;
            frame_start        <= enable && (h_cnt == '0) && (v_cnt == '0);
            underrun           <= vis && empty;
            hsync              <= h_on ? SYNC_POL : !SYNC_POL;
            vsync              <= v_on ? SYNC_POL : !SYNC_POL;
        end
    end

`ifdef VGA_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) underrun_cnt <= '0;
        else if (vis && empty && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 1'b1;
    end
`endif
endmodule
